// File: rtl/memory_arbiter.sv
// Serialises instruction-read, data-read and data-write requests onto one
// variable-latency RAM port, returning one-cycle hits and a sticky watchdog flag.
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iren,
    input  logic [31:0] iaddr,
    input  logic        dren,
    input  logic        wren,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] instr,
    output logic        dhit,
    output logic [31:0] dload,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    input  logic [31:0] ramload,
    input  logic        ram_ack,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, RESP} state_t;

    localparam logic [7:0]  TIMEOUT_CNT = TIMEOUT[7:0];
    localparam logic [31:0] BAD_DATA    = 32'hDEADBEEF;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        done;

    // RAM side is decoded purely from state and latched registers.
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ramREN   = (state == IREAD) || (state == DREAD);
    assign ramWEN   = (state == DWRITE);
    assign done     = ram_ack || (cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            store_q <= '0;
            ihit    <= 1'b0;
            dhit    <= 1'b0;
            instr   <= '0;
            dload   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ihit <= 1'b0;
                    dhit <= 1'b0;
                    cnt  <= '0;
                    if (wren) begin
                        addr_q  <= daddr;
                        store_q <= dstore;
                        state   <= DWRITE;
                    end else if (dren) begin
                        addr_q  <= daddr;
                        store_q <= dstore;
                        state   <= DREAD;
                    end else if (iren) begin
                        addr_q <= iaddr;
                        state  <= IREAD;
                    end
                end
                IREAD, DREAD, DWRITE: begin
                    if (done) begin
                        state <= RESP;
                        ihit  <= (state == IREAD);
                        dhit  <= (state != IREAD);
                        // An ack arriving on the timeout cycle still counts as success.
                        if (!ram_ack)
                            err <= 1'b1;
                        if (state == IREAD)
                            instr <= ram_ack ? ramload : BAD_DATA;
                        if (state == DREAD)
                            dload <= ram_ack ? ramload : BAD_DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: request tasks push expected hits,
// an independent negedge monitor pops and compares on every ihit/dhit.
module tb_memory_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        iren, dren, wren;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit;
    logic [31:0] instr, dload;
    logic [31:0] ramaddr, ramstore;
    logic        ramREN, ramWEN;
    logic [31:0] ramload;
    logic        ram_ack;
    logic        err;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .iren(iren), .iaddr(iaddr), .dren(dren), .wren(wren),
        .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .instr(instr), .dhit(dhit), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ram_ack(ram_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_i;
        bit          is_read;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   hits       = 0;
    int   hit_steps;
    bit   err_exp    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: decoupled from stimulus, compares every presented hit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) chk("en_exclusive", {31'd0, ramREN & ramWEN}, 32'd0);
        if (ihit || dhit) begin
            hits++;
            if (sb.size() == 0) begin
                chk("unexpected_hit", {30'd0, ihit, dhit}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("hit_kind", {30'd0, ihit, dhit}, e.is_i ? 32'd2 : 32'd1);
                if (e.is_read) begin
                    if (e.is_i) chk("instr", instr, e.data);
                    else        chk("dload", dload, e.data);
                end
                chk("err_on_hit", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    task automatic push(input bit is_i, input bit is_read, input logic [31:0] data, input bit e);
        exp_t x;
        x.is_i = is_i; x.is_read = is_read; x.data = data; x.err = e;
        sb.push_back(x);
    endtask

    // RAM model: acks on access cycle `lat` (0 = never); hit_steps = cycles to hit.
    task automatic serve(input int lat, input logic [31:0] data, input logic [31:0] exp_addr,
                         input bit is_wr, input logic [31:0] exp_store, input bit alter);
        int n = 0;
        hit_steps = -1;
        while (!(ramREN || ramWEN) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!(ramREN || ramWEN)) begin
            chk("enable_wait", {31'd0, ramREN | ramWEN}, 32'd1);
            return;
        end
        for (int i = 1; i <= 40; i++) begin
            chk("ram_en", {31'd0, is_wr ? ramWEN : ramREN}, 32'd1);
            chk("ramaddr", ramaddr, exp_addr);
            if (is_wr) chk("ramstore", ramstore, exp_store);
            if (alter && i == 1) daddr = daddr + 32'd4;
            ramload = 32'h11111111;
            if (i == lat) begin
                ram_ack = 1'b1;
                ramload = data;
            end
            @(negedge clk);
            ram_ack = 1'b0;
            if (ihit || dhit) begin
                hit_steps = i;
                chk("en_off_in_resp", {30'd0, ramREN, ramWEN}, 32'd0);
                return;
            end
        end
        chk("hit_wait", 32'd0, 32'd1);
    endtask

    // kind: 0 = instruction read, 1 = data read, 2 = data write
    task automatic req(input int kind, input logic [31:0] addr, input logic [31:0] store,
                       input logic [31:0] data, input int lat, input bit alter);
        logic [31:0] expd;
        expd = (lat == 0) ? 32'hDEADBEEF : data;
        if (lat == 0) err_exp = 1;
        case (kind)
            0: begin iren = 1; iaddr = addr; end
            1: begin dren = 1; daddr = addr; end
            default: begin wren = 1; daddr = addr; dstore = store; end
        endcase
        push(kind == 0, kind != 2, expd, err_exp);
        serve(lat, data, addr, kind == 2, store, alter);
        chk("hit_latency", hit_steps, (lat == 0) ? TO + 1 : lat);
        iren = 0; dren = 0; wren = 0;
        @(negedge clk);
    endtask

    task automatic chk_reset;
        chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
    endtask

    initial begin
        int h0;
        rst = 1; iren = 0; dren = 0; wren = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk_reset();
        rst = 0;
        @(negedge clk);

        // Single fetch, ack on third access cycle
        req(0, 32'h100, 32'h0, 32'h8C220004, 3, 0);

        // Write beats simultaneous fetch
        wren = 1; iren = 1; daddr = 32'h200; dstore = 32'h12345678; iaddr = 32'h104;
        push(0, 0, 32'h0, 0);
        push(1, 1, 32'hAABBCCDD, 0);
        serve(2, 32'h0, 32'h200, 1, 32'h12345678, 0);
        chk("wr_latency", hit_steps, 2);
        wren = 0;
        @(negedge clk);
        serve(1, 32'hAABBCCDD, 32'h104, 0, 32'h0, 0);
        chk("rd_after_wr_latency", hit_steps, 1);
        iren = 0;
        @(negedge clk);

        // Fetch -> load -> fetch, exactly three services
        h0 = hits;
        req(0, 32'h108, 32'h0, 32'h00000111, 1, 0);
        req(1, 32'h300, 32'h0, 32'hCAFEF00D, 2, 0);
        req(0, 32'h10C, 32'h0, 32'h00000222, 1, 0);
        @(negedge clk);
        chk("seq_hit_count", hits - h0, 32'd3);
        chk("dload_holds", dload, 32'hCAFEF00D);

        // Address change mid-DREAD is ignored
        req(1, 32'h400, 32'h0, 32'h0BADF00D, 3, 1);

        // Watchdog: no ack, then err stays set through normal accesses
        req(1, 32'h500, 32'h0, 32'h0, 0, 0);
        req(0, 32'h110, 32'h0, 32'h00000333, 2, 0);
        req(2, 32'h600, 32'h55AA55AA, 32'h0, 1, 0);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of an instruction read
        iren = 1; iaddr = 32'h700;
        @(negedge clk);
        @(negedge clk);
        chk("iread_active", {31'd0, ramREN}, 32'd1);
        rst = 1;
        #1;
        chk_reset();
        @(negedge clk);
        chk_reset();
        rst = 0; iren = 0;
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Memory-side responder for the pipeline's request unit. It accepts instruction-read, data-read and data-write requests, serialises them onto one single-ported RAM with variable latency, and returns one-cycle `ihit`/`dhit` completions with registered read data. It sits between the request unit and the RAM model/controller. A watchdog flags RAM accesses that never complete.

## Interface
- `TIMEOUT`, 255: maximum cycles in an access state before forced completion; 8-bit counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `iren`  in  1  instruction read request; held until `ihit`.
- `iaddr`  in  32  instruction address.
- `dren`  in  1  data read request; held until `dhit`.
- `wren`  in  1  data write request; held until `dhit`.
- `daddr`  in  32  data address.
- `dstore`  in  32  write data.
- `ihit`  out  1  one-cycle instruction completion.
- `instr`  out  32  fetched instruction; valid while `ihit`=1, holds value afterwards.
- `dhit`  out  1  one-cycle data completion, for both read and write.
- `dload`  out  32  read data; valid while `dhit`=1 after a read, holds value afterwards.
- `ramaddr`  out  32  RAM address, from latched request.
- `ramstore`  out  32  RAM write data, from latched request.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramload`  in  32  RAM read data; valid when `ram_ack`=1.
- `ram_ack`  in  1  RAM access complete this cycle.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, IREAD, DREAD, DWRITE, RESP.
- IDLE: sample requests. Priority is `wren` > `dren` > `iren`.
  - Winner latches `daddr`/`iaddr` and `dstore` into internal registers.
  - Winner moves to DWRITE, DREAD or IREAD.
  - With no request, stay in IDLE.
- Access states:
  - `ramREN`=1 in IREAD and DREAD. `ramWEN`=1 in DWRITE.
  - `ramaddr`/`ramstore` are driven from the latched registers, so input changes are ignored mid-access.
  - On `ram_ack`=1, go to RESP, record the requester type, and capture `ramload` into `instr` (IREAD) or `dload` (DREAD). DWRITE captures nothing.
  - Never assert `ramREN` and `ramWEN` together. Both are 0 in IDLE and RESP.
- Watchdog:
  - An 8-bit counter clears on entering an access state and increments each cycle in it.
  - When it reaches `TIMEOUT` without `ram_ack`, go to RESP anyway and set `err`=1. `err` is sticky until `rst`.
  - On a timed-out read, the captured data is 0xDEADBEEF.
- RESP: pulse `ihit` (IREAD) or `dhit` (DREAD/DWRITE) for exactly one cycle, then return to IDLE.
- A request deasserted mid-access is not aborted. The RAM access completes and the hit still pulses; the initiator ignores it.
- A held request is never served twice. The initiator changes its request on the hit edge, and IDLE samples only after RESP.
- Reset:
  - State goes to IDLE; all outputs go to 0 (`ihit`, `dhit`, `ramREN`, `ramWEN`, `err`, `instr`, `dload`, `ramaddr`, `ramstore`).
  - The counter and latched registers clear.
  - Reset during an access drops it immediately, with no hit.

## Timing
- Cycle 0: request high in IDLE, latched at the edge.
- Cycle 1 onward: access state with RAM enable asserted.
- `ram_ack` sampled high in cycle k gives RESP in cycle k+1, with the hit and data visible that cycle.
- Minimum latency is request-to-hit = 2 cycles, with `ram_ack` in cycle 1.
- Back-to-back: a new request seen in the IDLE cycle after RESP starts an access the cycle after. The pipeline overhead per access is 2 cycles beyond RAM latency.
- Hit, `instr`, `dload` and `err` are registered. RAM enables and address are decoded from state and registers only, with no combinational path from request inputs.
- Watchdog: with no ack, the hit lands `TIMEOUT`+1 cycles after entering the access state.

## Test plan
- Reset then `iren`=1, `iaddr`=0x100, RAM acks after 3 cycles with 0x8C220004 -> `ramREN`=1 with `ramaddr`=0x100 for 3 cycles; `ihit`=1 for one cycle with `instr`=0x8C220004; `dhit`=0.
- `wren`=1 and `iren`=1 together, `daddr`=0x200, `dstore`=0x12345678 -> DWRITE first (`ramWEN`=1, `ramstore`=0x12345678), `dhit` pulse, then the instruction read.
- Request-unit sequence fetch -> `dren` at 0x300 (RAM returns 0xCAFEF00D) -> fetch -> `dload`=0xCAFEF00D on `dhit`, exactly 3 hits total, no duplicate service.
- Change `daddr` from 0x400 to 0x404 mid DREAD -> `ramaddr` stays 0x400 until RESP.
- `ram_ack` held 0 with `TIMEOUT`=4 -> `dhit` 5 cycles after entering DREAD, `dload`=0xDEADBEEF, `err`=1 and stays 1 through later successful accesses.
- Assert `rst` mid IREAD -> next cycle `ramREN`=0, no `ihit`, all outputs 0, `err`=0.
